// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into 32-bit
// instruction-memory writes, holding the core in reset until the image is in.
// Optional trailing XOR checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q;
    // One extra bit so the index can reach N == 2**ADDR_W without wrapping.
    logic [ADDR_W:0]   idx_q;
    logic [ADDR_W:0]   idx_inc;
    logic [1:0]        byte_cnt_q;
    logic [23:0]       word_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic        xfer;
    logic [15:0] len_full;
    logic        len_bad;
    logic        last_word;

    assign xfer      = rx_valid && rx_ready;
    assign len_full  = {rx_data, n_q[7:0]};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > 32'(MAX_WORDS));
    assign idx_inc   = idx_q + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word = (32'(idx_inc) == 32'(n_q));

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN0;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        rx_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        cpu_rst  = 1'b1;
        unique case (state_q)
            S_LEN0: begin
                rx_ready = 1'b1;
                if (xfer) state_d = S_LEN1;
            end
            S_LEN1: begin
                rx_ready = 1'b1;
                if (xfer) state_d = len_bad ? S_ERR : S_DATA;
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (xfer && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
            end
            S_WRITE: begin
                imem_we = 1'b1;
                if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                cpu_rst = 1'b0;
                if (start) state_d = S_LEN0;
            end
            S_ERR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) state_d = S_LEN0;
            end
            default: state_d = S_LEN0;
        endcase
    end

    // Datapath; the write address/data are captured with the 4th byte so they
    // are stable during WRITE and simply hold afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q        <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                S_LEN0: begin
`ifdef BOOT_CHECKSUM_EN
                    csum_q <= '0;
`endif
                    if (xfer) n_q[7:0] <= rx_data;
                end
                S_LEN1: begin
                    if (xfer) begin
                        n_q[15:8]  <= rx_data;
                        idx_q      <= '0;
                        byte_cnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef BOOT_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data;
`endif
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        case (byte_cnt_q)
                            2'd0: word_q[7:0]   <= rx_data;
                            2'd1: word_q[15:8]  <= rx_data;
                            2'd2: word_q[23:16] <= rx_data;
                            default: begin
                                addr_q  <= idx_q[ADDR_W-1:0];
                                wdata_q <= {rx_data, word_q};
                            end
                        endcase
                    end
                end
                S_WRITE: idx_q <= idx_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream loader for the single-cycle RISC-V processor. It receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the instruction memory write port. The processor core is held in reset until the image is fully loaded, which replaces simulation-only memory preloading with a synthesizable boot path.

Parameters:
ADDR_W, 8, instruction memory word-address width
MAX_WORDS, 256, largest accepted image in words; must be <= 2**ADDR_W

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_valid  input  1  byte available on rx_data
rx_data  input  8  incoming byte
rx_ready  output  1  loader can accept a byte this cycle
start  input  1  single-cycle pulse; re-arms the loader from DONE or ERR
imem_we  output  1  instruction memory write enable
imem_addr  output  ADDR_W  instruction memory word address
imem_wdata  output  32  instruction word to write
cpu_rst  output  1  reset to the processor core; high until load completes
busy  output  1  load in progress (states LEN0..WRITE)
done  output  1  image loaded successfully
error  output  1  image rejected

Behaviour:
- Byte transfer occurs on a rising clk edge when rx_valid && rx_ready. No transfer occurs otherwise, and rx_data is ignored.
- Frame format:
  - 2-byte word count N, low byte first.
  - Then N*4 data bytes; each word is little-endian (first byte goes to bits [7:0]).
- States:
  - LEN0: rx_ready=1. On transfer, latch N[7:0] and go to LEN1.
  - LEN1: rx_ready=1. On transfer, latch N[15:8]. If N==0 or N>MAX_WORDS go to ERR, else go to DATA with word index=0 and byte count=0.
  - DATA: rx_ready=1. On transfer, place the byte in lane byte_cnt and increment byte_cnt (2 bits). After the 4th byte go to WRITE.
  - WRITE: rx_ready=0. imem_we=1 for exactly this one cycle, with imem_addr=index and imem_wdata=assembled word. Increment index. If the new index==N go to DONE (or CSUM with the option), else go to DATA.
  - DONE: rx_ready=0, done=1, cpu_rst=0. A start pulse returns to LEN0.
  - ERR: rx_ready=0, error=1, cpu_rst=1. A start pulse returns to LEN0.
- Latency: imem_we asserts the cycle after the 4th byte of a word is accepted. cpu_rst falls the cycle after the final WRITE (or CSUM transfer).
- imem_addr and imem_wdata hold their last values when imem_we=0. Memory must only sample them when imem_we=1.
- cpu_rst=1 in every state except DONE.
- start is ignored in LEN0..WRITE; a load in progress is never aborted by start.
- Reset, including mid-load, gives:
  - state=LEN0, index=0, byte_cnt=0, N=0
  - rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_rst=1, busy=1, done=0, error=0
- Words already written before a mid-load reset stay in memory and are overwritten by the next load.
- A partial trailing word (stream stops mid-word) leaves the loader waiting in DATA indefinitely; no timeout.
- N==MAX_WORDS is legal. The last write goes to address MAX_WORDS-1 and the index never wraps.

Optional Feature:
BOOT_CHECKSUM_EN
- Defined:
  - After the last WRITE, enter state CSUM (rx_ready=1, busy=1) and accept one byte.
  - That byte is compared with the running XOR of all 4*N data bytes (length bytes excluded, XOR reset in LEN0).
  - Match goes to DONE; mismatch goes to ERR.
  - All words remain written in either case.
- Undefined: no CSUM state; the last WRITE goes directly to DONE.

Test Plan:
1. Reset, then stream 01 00 | 93 00 10 00 → single write imem_addr=0, imem_wdata=0x00100093; next cycle done=1, cpu_rst=0.
2. Stream N=3 with words 0x00200113, 0x002081B3, 0x00000063, rx_valid held high → three imem_we pulses at addrs 0,1,2; rx_ready low exactly on each WRITE cycle; no bytes lost.
3. Stream 00 00 → error=1, rx_ready=0, cpu_rst=1. Then pulse start and stream 01 00 + 4 bytes → done=1.
4. Stream N=0x0101 (257) with MAX_WORDS=256 → ERR after the 2nd byte; stream N=256 → 256 writes, last at addr 0xFF, then done.
5. Assert rst after 6 data bytes of an N=2 load → all outputs at reset values next cycle. A fresh N=1 load then writes addr 0.
6. With BOOT_CHECKSUM_EN, N=1 word 0x11223344 and csum byte 0x44 → done. The same stream with csum 0x45 → error=1, cpu_rst=1.
